// File: rtl/cfeb_trg_if.sv
// Trigger bus between the ENC_TRG pins/JTAG configuration and the CFEB trigger decoder.
// The master drives the encoded trigger and mode bits; the slave returns the decoded strobes.
interface cfeb_trg_if;
  logic [2:0] enc_trg;
  logic       trg_dcd;
  logic       mtch_3bx;
  logic       lat_12_5us;
  logic       lct;
  logic       l1a;
  logic       l1a_match;
  logic       resync;
  logic       nomatch;
  logic [5:0] l1a_cnt;

  modport master (
    output enc_trg, trg_dcd, mtch_3bx, lat_12_5us,
    input  lct, l1a, l1a_match, resync, nomatch, l1a_cnt
  );

  modport slave (
    input  enc_trg, trg_dcd, mtch_3bx, lat_12_5us,
    output lct, l1a, l1a_match, resync, nomatch, l1a_cnt
  );
endinterface

// File: rtl/cfeb_trg_decode.sv
// Registered CFEB trigger front end: samples ENC_TRG, decodes LCT/L1A/L1A_MATCH/RESYNC,
// forms the direct-mode L1A match from the LCT history and keeps the 6-bit L1A number.
module cfeb_trg_decode #(
  parameter int LAT_SHORT = 128,
  parameter int LAT_LONG  = 500,
  parameter int RSYNC_LEN = 4
) (
  input  logic      CLK,
  input  logic      RST_B,
  cfeb_trg_if.slave trg
);

  localparam int         IW          = $clog2(LAT_LONG + 1) + 1;
  localparam logic [3:0] RSYNC_INIT  = 4'(RSYNC_LEN);

  logic [2:0]          enc_q, enc_d;
  logic                lct_q, lct_d;
  logic                l1a_q, l1a_d;
  logic                match_q, match_d;
  logic                nomatch_q, nomatch_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [3:0]          rs_q, rs_d;
  logic [LAT_LONG-1:0] hist_q, hist_d;

  logic [LAT_LONG:0]   h_all;
  logic [IW-1:0]       lat_idx;
  logic                dec_lct, dec_l1a, dec_match, dec_resync;
  logic                win_match, blocked;

  always_comb begin
    dec_lct    = 1'b0;
    dec_l1a    = 1'b0;
    dec_match  = 1'b0;
    dec_resync = 1'b0;
    if (trg.trg_dcd) begin
      case (enc_q)
        3'd1: dec_lct = 1'b1;
        3'd2: begin dec_lct = 1'b1; dec_l1a = 1'b1; end
        3'd3: begin dec_lct = 1'b1; dec_l1a = 1'b1; dec_match = 1'b1; end
        3'd4: dec_l1a = 1'b1;
        3'd5: begin dec_l1a = 1'b1; dec_match = 1'b1; end
        3'd7: dec_resync = 1'b1;
        default: ;
      endcase
    end else begin
      // resync bit dominates: a 3'b111 pattern is a pure resync
      dec_resync = enc_q[2];
      dec_lct    = enc_q[0] & ~enc_q[2];
      dec_l1a    = enc_q[1] & ~enc_q[2];
    end
  end

  // h_all[k-1] is the LCT output k cycles before the L1A output cycle being formed
  always_comb begin
    h_all     = {hist_q, lct_q};
    lat_idx   = trg.lat_12_5us ? IW'(LAT_LONG - 1) : IW'(LAT_SHORT - 1);
    win_match = h_all[lat_idx]
              | (trg.mtch_3bx & (h_all[lat_idx - IW'(1)] | h_all[lat_idx + IW'(1)]));
  end

  always_comb begin
    blocked   = dec_resync | (rs_q != 4'd0);
    enc_d     = trg.enc_trg;
    lct_d     = dec_lct & ~blocked;
    l1a_d     = dec_l1a & ~blocked;
    match_d   = 1'b0;
    nomatch_d = 1'b0;
    if (trg.trg_dcd) begin
      match_d = l1a_d & dec_match;
    end else begin
      match_d   = l1a_d & win_match;
      nomatch_d = l1a_d & ~win_match;
    end

    if (dec_resync)
      rs_d = RSYNC_INIT;
    else if (rs_q != 4'd0)
      rs_d = rs_q - 4'd1;
    else
      rs_d = 4'd0;

    // the count reflects the L1A strobe of the previous cycle
    cnt_d  = blocked ? 6'd0 : cnt_q + {5'd0, l1a_q};
    hist_d = dec_resync ? '0 : {hist_q[LAT_LONG-2:0], lct_q};
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      enc_q     <= 3'd0;
      lct_q     <= 1'b0;
      l1a_q     <= 1'b0;
      match_q   <= 1'b0;
      nomatch_q <= 1'b0;
      cnt_q     <= 6'd0;
      rs_q      <= RSYNC_INIT;
      hist_q    <= '0;
    end else begin
      enc_q     <= enc_d;
      lct_q     <= lct_d;
      l1a_q     <= l1a_d;
      match_q   <= match_d;
      nomatch_q <= nomatch_d;
      cnt_q     <= cnt_d;
      rs_q      <= rs_d;
      hist_q    <= hist_d;
    end
  end

  assign trg.lct       = lct_q;
  assign trg.l1a       = l1a_q;
  assign trg.l1a_match = match_q;
  assign trg.nomatch   = nomatch_q;
  assign trg.resync    = (rs_q != 4'd0);
  assign trg.l1a_cnt   = cnt_q;

endmodule
